// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if
// Groups every bus signal of regfile_arbiter: the two write-back request
// ports (A = execute, B = load), the dual-operand read request/response
// port (R) and the register-file access port.
//   slave  : used by regfile_arbiter (takes requests, drives the RF)
//   master : used by whatever sits around it (requesters plus the RF)
interface regfile_arbiter_if;
    // execute-stage write-back (A)
    logic       a_wr_valid;
    logic       a_wr_ready;
    logic [1:0] a_wr_addr;
    logic [7:0] a_wr_data;
    // load-unit write-back (B)
    logic       b_wr_valid;
    logic       b_wr_ready;
    logic [1:0] b_wr_addr;
    logic [7:0] b_wr_data;
    // decode-stage read request (R)
    logic       rd_valid;
    logic       rd_ready;
    logic [1:0] rd_addr1;
    logic [1:0] rd_addr2;
    // buffered read response
    logic       rd_resp_valid;
    logic       rd_resp_ready;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;
    // register file access port
    logic       rf_wr_en;
    logic       rf_read_en;
    logic [1:0] rf_dest_1;
    logic [1:0] rf_dest_2;
    logic [7:0] rf_data;
    logic [7:0] rf_data_read_1;
    logic [7:0] rf_data_read_2;

    modport slave (
        input  a_wr_valid, a_wr_addr, a_wr_data,
        input  b_wr_valid, b_wr_addr, b_wr_data,
        input  rd_valid, rd_addr1, rd_addr2, rd_resp_ready,
        input  rf_data_read_1, rf_data_read_2,
        output a_wr_ready, b_wr_ready, rd_ready,
        output rd_resp_valid, rd_data1, rd_data2,
        output rf_wr_en, rf_read_en, rf_dest_1, rf_dest_2, rf_data
    );

    modport master (
        output a_wr_valid, a_wr_addr, a_wr_data,
        output b_wr_valid, b_wr_addr, b_wr_data,
        output rd_valid, rd_addr1, rd_addr2, rd_resp_ready,
        output rf_data_read_1, rf_data_read_2,
        input  a_wr_ready, b_wr_ready, rd_ready,
        input  rd_resp_valid, rd_data1, rd_data2,
        input  rf_wr_en, rf_read_en, rf_dest_1, rf_dest_2, rf_data
    );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
// Shares the single access port of a 4 x 8-bit register file between two
// write-back requesters (A, B) and one dual-operand read requester (R).
// At most one requester is granted per cycle, round-robin in the circular
// order R -> A -> B, starting after the last granted requester. A read
// result appears on the RF outputs one cycle after the grant, is captured
// and then held in a valid/ready response register.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - regfile_arbiter_if.slave (requests, response, RF port)
// Optional feature: define REGARB_RAW_GUARD_EN to block a read while any
// pending write targets one of its operand registers.
module regfile_arbiter (
    input  logic             clk,
    input  logic             rst,
    regfile_arbiter_if.slave bus
);
    // requester indices, in circular priority order
    localparam logic [1:0] REQ_R = 2'd0;
    localparam logic [1:0] REQ_A = 2'd1;
    localparam logic [1:0] REQ_B = 2'd2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_HOLD = 2'd2
    } rd_state_e;

    rd_state_e  r_state;
    rd_state_e  w_state_next;
    logic [1:0] r_last_grant;
    logic [7:0] r_rd_data1;
    logic [7:0] r_rd_data2;

    logic       w_raw_ok;
    logic [3:0] w_elig;        // bit 3 is padding so any 2-bit index is legal
    logic [1:0] w_cand [3];    // w_cand[k] = requester k+1 slots after last grant
    logic       w_gnt_any;
    logic [1:0] w_gnt_idx;

`ifdef REGARB_RAW_GUARD_EN
    // hold the read back while a pending write targets one of its operands
    always_comb begin
        w_raw_ok = 1'b1;
        if (bus.a_wr_valid &&
            (bus.a_wr_addr == bus.rd_addr1 || bus.a_wr_addr == bus.rd_addr2))
            w_raw_ok = 1'b0;
        if (bus.b_wr_valid &&
            (bus.b_wr_addr == bus.rd_addr1 || bus.b_wr_addr == bus.rd_addr2))
            w_raw_ok = 1'b0;
    end
`else
    assign w_raw_ok = 1'b1;
`endif

    // gating with rst keeps every combinational output at 0 during reset
    assign w_elig = {1'b0,
                     bus.b_wr_valid & ~rst,
                     bus.a_wr_valid & ~rst,
                     bus.rd_valid & (r_state == R_IDLE) & w_raw_ok & ~rst};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cand
            logic [2:0] w_sum;
            assign w_sum       = {1'b0, r_last_grant} + 3'(gi + 1);
            assign w_cand[gi]  = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
        end
    endgenerate

    // scan from the farthest candidate to the nearest so the nearest wins
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = r_last_grant;
        for (int k = 2; k >= 0; k--) begin
            if (w_elig[w_cand[k]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand[k];
            end
        end
    end

    // grant decode: readies and register-file port
    always_comb begin
        bus.a_wr_ready = 1'b0;
        bus.b_wr_ready = 1'b0;
        bus.rd_ready   = 1'b0;
        bus.rf_wr_en   = 1'b0;
        bus.rf_read_en = 1'b0;
        bus.rf_dest_1  = 2'd0;
        bus.rf_dest_2  = 2'd0;
        bus.rf_data    = 8'd0;
        if (w_gnt_any) begin
            case (w_gnt_idx)
                REQ_R: begin
                    bus.rd_ready   = 1'b1;
                    bus.rf_read_en = 1'b1;
                    bus.rf_dest_1  = bus.rd_addr1;
                    bus.rf_dest_2  = bus.rd_addr2;
                end
                REQ_A: begin
                    bus.a_wr_ready = 1'b1;
                    bus.rf_wr_en   = 1'b1;
                    bus.rf_dest_1  = bus.a_wr_addr;
                    bus.rf_data    = bus.a_wr_data;
                end
                REQ_B: begin
                    bus.b_wr_ready = 1'b1;
                    bus.rf_wr_en   = 1'b1;
                    bus.rf_dest_1  = bus.b_wr_addr;
                    bus.rf_data    = bus.b_wr_data;
                end
                default: ;
            endcase
        end
    end

    // last_grant starts at B so R has first priority out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_grant <= REQ_B;
        else if (w_gnt_any)
            r_last_grant <= w_gnt_idx;
    end

    // read FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= R_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            R_IDLE:  if (w_gnt_any && w_gnt_idx == REQ_R) w_state_next = R_WAIT;
            R_WAIT:  w_state_next = R_HOLD;
            R_HOLD:  if (bus.rd_resp_ready) w_state_next = R_IDLE;
            default: w_state_next = R_IDLE;
        endcase
    end

    // RF read outputs are valid only in the cycle after the read grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data1 <= 8'd0;
            r_rd_data2 <= 8'd0;
        end else if (r_state == R_WAIT) begin
            r_rd_data1 <= bus.rf_data_read_1;
            r_rd_data2 <= bus.rf_data_read_2;
        end
    end

    assign bus.rd_resp_valid = (r_state == R_HOLD);
    assign bus.rd_data1      = r_rd_data1;
    assign bus.rd_data2      = r_rd_data2;
endmodule
